// File: rtl/temp_fmt_pkg.sv
// Shared constants and state type for the DS18B20-to-ASCII framer.
// Holds the ASCII codes, the raw reading's field widths and a digit-to-character helper.
package temp_fmt_pkg;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  localparam int INT_W  = 7;
  localparam int FRAC_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CONVERT = 2'd2,
    SEND    = 2'd3
  } fmt_state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return CH_ZERO + {4'b0000, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: converts a 7-bit integer into three BCD digits, one bit per enabled cycle.
// done is high during the cycle whose clock edge performs the final shift.
module bin2bcd_seq
  import temp_fmt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [INT_W-1:0] bin,
  output logic [11:0]      bcd,
  output logic             done
);

  logic [12+INT_W-1:0] sh;
  logic [2:0]          cnt;
  logic                run;
  logic [11:0]         adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (sh[INT_W+i*4 +: 4] >= 4'd5) ? sh[INT_W+i*4 +: 4] + 4'd3
                                                    : sh[INT_W+i*4 +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (ena) begin
      if (load) begin
        sh  <= {12'd0, bin};
        cnt <= '0;
        run <= 1'b1;
      end else if (run) begin
        sh  <= {adj[10:0], sh[INT_W-1:0], 1'b0};
        cnt <= cnt + 3'd1;
        if (cnt == 3'(INT_W - 1)) run <= 1'b0;
      end
    end
  end

  assign bcd  = sh[12+INT_W-1:INT_W];
  assign done = run && (cnt == 3'(INT_W - 1));

endmodule

// File: rtl/temp_ascii_framer.sv
// Captures a raw DS18B20 reading on start, converts it to "+HTU.t" (optionally CR LF)
// and streams it byte-wise over valid/ready.
module temp_ascii_framer
  import temp_fmt_pkg::*;
#(
  parameter bit         APPEND_CRLF = 1'b1,
  parameter logic [7:0] POS_CHAR    = 8'h2B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [15:0] temp_raw,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        sat,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte moves on a clock edge where tx_valid && tx_ready; once raised,
  // tx_valid and tx_data stay put until that edge (only reset can withdraw them).
  localparam logic [2:0] LAST_IDX = APPEND_CRLF ? 3'd7 : 3'd5;

  fmt_state_t state, state_d;
  logic [15:0] raw_q, raw_d;
  logic        neg_q, neg_d;
  logic [3:0]  tenths_q, tenths_d;
  logic [2:0]  idx, idx_d, nxt_idx;
  logic [7:0]  tx_data_d, nxt_byte;
  logic        tx_valid_d, busy_d, done_q, done_d, sat_d;

  logic [15:0]      mag;
  logic [7:0]       frac_x10;
  logic             cap_sat;
  logic [INT_W-1:0] cap_int;
  logic [3:0]       cap_tenths;
  logic             conv_load, conv_done;
  logic [11:0]      bcd;

  // -0x8000 negates back to 0x8000, which lands in the saturation branch.
  always_comb begin
    mag        = raw_q[15] ? (~raw_q + 16'd1) : raw_q;
    frac_x10   = {4'b0000, mag[FRAC_W-1:0]} * 8'd10;
    cap_sat    = |mag[15:11];
    cap_int    = mag[10:4];
    cap_tenths = frac_x10[7:4];
    if (cap_sat) begin
      cap_int    = 7'd127;
      cap_tenths = 4'd9;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .load  (conv_load),
    .bin   (cap_int),
    .bcd   (bcd),
    .done  (conv_done)
  );

  always_comb begin
    nxt_idx  = idx + 3'd1;
    nxt_byte = 8'h00;
    case (nxt_idx)
      3'd0:    nxt_byte = neg_q ? CH_MINUS : POS_CHAR;
      3'd1:    nxt_byte = digit_char(bcd[11:8]);
      3'd2:    nxt_byte = digit_char(bcd[7:4]);
      3'd3:    nxt_byte = digit_char(bcd[3:0]);
      3'd4:    nxt_byte = CH_DOT;
      3'd5:    nxt_byte = digit_char(tenths_q);
      3'd6:    nxt_byte = CH_CR;
      default: nxt_byte = CH_LF;
    endcase
  end

  always_comb begin
    state_d    = state;
    raw_d      = raw_q;
    neg_d      = neg_q;
    tenths_d   = tenths_q;
    idx_d      = idx;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    busy_d     = busy;
    done_d     = 1'b0;
    sat_d      = sat;
    conv_load  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          raw_d   = temp_raw;
          busy_d  = 1'b1;
          sat_d   = 1'b0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        neg_d     = raw_q[15];
        tenths_d  = cap_tenths;
        sat_d     = cap_sat;
        conv_load = 1'b1;
        state_d   = CONVERT;
      end
      CONVERT: begin
        if (conv_done) begin
          idx_d      = 3'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = neg_q ? CH_MINUS : POS_CHAR;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d     = nxt_idx;
            tx_data_d = nxt_byte;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      raw_q    <= '0;
      neg_q    <= 1'b0;
      tenths_q <= '0;
      idx      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done_q   <= 1'b0;
      sat      <= 1'b0;
    end else if (ena) begin
      state    <= state_d;
      raw_q    <= raw_d;
      neg_q    <= neg_d;
      tenths_q <= tenths_d;
      idx      <= idx_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      busy     <= busy_d;
      done_q   <= done_d;
      sat      <= sat_d;
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done      = done_q && ena;
  assign dbg_state = state;

endmodule

// File: tb/tb_temp_ascii_framer.sv
// Bench for temp_ascii_framer: table vectors, hand sequences for stalls/reset/enable,
// and random readings against an arithmetic reference model.
module tb_temp_ascii_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        start = 1'b0, start6 = 1'b0;
  logic [15:0] temp_raw = '0, temp_raw6 = '0;
  logic        tx_ready = 1'b1, tx_ready6 = 1'b1;
  logic [7:0]  tx_data, tx_data6;
  logic        tx_valid, tx_valid6, busy, busy6, done, done6, sat, sat6;
  logic [1:0]  dbg_state, dbg_state6;

  temp_ascii_framer #(.APPEND_CRLF(1'b1), .POS_CHAR(8'h2B)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .temp_raw(temp_raw),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .sat(sat), .dbg_state(dbg_state));

  temp_ascii_framer #(.APPEND_CRLF(1'b0), .POS_CHAR(8'h2B)) dut6 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start6), .temp_raw(temp_raw6),
    .tx_data(tx_data6), .tx_valid(tx_valid6), .tx_ready(tx_ready6),
    .busy(busy6), .done(done6), .sat(sat6), .dbg_state(dbg_state6));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp6_q[$];
  int done_cnt = 0;
  int bytes6 = 0;

  typedef struct {
    logic [15:0] raw;
    logic [47:0] text;
    logic        sat;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value in sixteenths -> integer and truncated tenths, decimal digits by division.
  task automatic model_frame(input logic [15:0] raw, output logic [63:0] b, output logic s);
    int v, a, ip, t;
    v = int'($signed(raw));
    a = (v < 0) ? -v : v;
    if (a >= 128 * 16) begin
      s = 1'b1; ip = 127; t = 9;
    end else begin
      s = 1'b0; ip = a / 16; t = ((a % 16) * 10) / 16;
    end
    b = {(v < 0) ? 8'h2D : 8'h2B, 8'(48 + ip / 100), 8'(48 + (ip / 10) % 10),
         8'(48 + ip % 10), 8'h2E, 8'(48 + t), 8'h0D, 8'h0A};
  endtask

  task automatic push_model(input logic [15:0] raw, input bit six, output logic s);
    logic [63:0] b;
    model_frame(raw, b, s);
    for (int i = 0; i < (six ? 6 : 8); i++) begin
      if (six) exp6_q.push_back(b[63-8*i -: 8]);
      else     exp_q.push_back(b[63-8*i -: 8]);
    end
  endtask

  task automatic push_text(input logic [47:0] t);
    for (int i = 5; i >= 0; i--) exp_q.push_back(t[i*8 +: 8]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Scoreboards: every transfer on either DUT is popped against its expected queue.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && ena && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL byte: got %0h expected no transfer", tx_data);
      end else begin
        chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && ena && tx_valid6 && tx_ready6) begin
      bytes6++;
      if (exp6_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL byte6: got %0h expected no transfer", tx_data6);
      end else begin
        chk("byte6", 32'(tx_data6), 32'(exp6_q.pop_front()));
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] raw, input bit rnd, input logic exp_sat,
                           input int gap, output int lat);
    int n, d0;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1; n++;
    end
    temp_raw = raw;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    temp_raw = 16'($urandom);
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("sat_clear_on_start", 32'(sat), 32'd0);
    d0 = done_cnt;
    n = 0;
    lat = -1;
    while (!done && n < 400) begin
      if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1; n++;
      if (lat < 0 && tx_valid) lat = n;
      if (gap > 0 && n == gap) ena = 1'b0;
      if (gap > 0 && n == gap + 10) ena = 1'b1;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("sat", 32'(sat), 32'(exp_sat));
    chk("busy_end", 32'(busy), 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, d0;
    logic s;
    logic [15:0] r;

    tbl[0]  = '{16'h0191, "+025.0", 1'b0};
    tbl[1]  = '{16'hFF5E, "-010.1", 1'b0};
    tbl[2]  = '{16'hFFF8, "-000.5", 1'b0};
    tbl[3]  = '{16'h07D0, "+125.0", 1'b0};
    tbl[4]  = '{16'h0800, "+127.9", 1'b1};
    tbl[5]  = '{16'h8000, "-127.9", 1'b1};
    tbl[6]  = '{16'h0000, "+000.0", 1'b0};
    tbl[7]  = '{16'hFFFF, "-000.0", 1'b0};
    tbl[8]  = '{16'h07FF, "+127.9", 1'b0};
    tbl[9]  = '{16'hF801, "-127.9", 1'b0};
    tbl[10] = '{16'hF800, "-127.9", 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_valid6", 32'(tx_valid6), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, including first-valid latency and saturation
    for (int i = 0; i < 11; i++) begin
      push_text(tbl[i].text);
      run_frame(tbl[i].raw, 1'b0, tbl[i].sat, 0, lat);
      chk("first_valid_latency", 32'(lat), 32'd8);
    end

    // Stall on byte 3 with a mid-frame start that must be ignored
    push_text(tbl[0].text);
    tx_ready = 1'b0;
    temp_raw = 16'h0191;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!tx_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("stall_valid_up", 32'(tx_valid), 32'd1);
    repeat (3) begin
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    d0 = done_cnt;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        start = 1'b1;
        temp_raw = 16'hFF5E;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("stall_data", 32'(tx_data), 32'h35);
      chk("stall_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    wait_done("stall_done");
    @(posedge clk); #1;
    chk("stall_done_count", 32'(done_cnt - d0), 32'd1);
    chk("stall_queue", 32'(exp_q.size()), 32'd0);
    chk("stall_idle", 32'(busy), 32'd0);

    // Six-byte variant, back-to-back start on the done cycle
    push_model(16'h0191, 1'b1, s);
    push_model(16'hFF5E, 1'b1, s);
    temp_raw6 = 16'h0191;
    start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    n = 0;
    while (!done6 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("six_done_a", 32'(done6), 32'd1);
    temp_raw6 = 16'hFF5E;
    start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    chk("six_b2b_busy", 32'(busy6), 32'd1);
    n = 0;
    while (!done6 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("six_done_b", 32'(done6), 32'd1);
    @(posedge clk); #1;
    chk("six_byte_count", 32'(bytes6), 32'd12);
    chk("six_queue", 32'(exp6_q.size()), 32'd0);

    // Asynchronous reset while byte 4 is offered, then a clean frame
    push_model(16'h07D0, 1'b0, s);
    tx_ready = 1'b0;
    temp_raw = 16'h07D0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!tx_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) begin
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    chk("rst_mid_byte4", 32'(tx_data), 32'h2E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    push_model(16'h07D0, 1'b0, s);
    run_frame(16'h07D0, 1'b0, s, 0, lat);
    chk("post_rst_latency", 32'(lat), 32'd8);

    // Enable held low for 10 cycles during CONVERT
    push_model(16'hFF5E, 1'b0, s);
    run_frame(16'hFF5E, 1'b0, s, 3, lat);
    chk("ena_gap_latency", 32'(lat), 32'd18);

    // Random readings with random back-pressure
    for (int k = 0; k < 30; k++) begin
      r = 16'($urandom);
      if (k % 2 == 1) r = {{4{r[11]}}, r[11:0]};
      push_model(r, 1'b0, s);
      run_frame(r, 1'b1, s, 0, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
